ysyx_25040111_rf_sb: RTL and testbench

//  Parametrised multi-port register file with an integrated busy-bit scoreboard.

---
 rtl/ysyx_25040111_rf_sb.sv | 117 +++++++++++
 tb/tb_ysyx_25040111_rf_sb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040111_rf_sb.sv
// Multi-port register file with a busy-bit scoreboard for RAW/WAW issue stalls.
// Reads are combinational and forward same-cycle write-back data; reg 0 is hardwired to zero.
module ysyx_25040111_rf_sb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 16,
    parameter int unsigned AW   = 4,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 2
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [NRD-1:0]      ren,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rrdy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic [NRD-1:0]  fwd_hit;
    logic [XLEN-1:0] fwd_data [NRD];
    logic            iss_wb_hit;

    // Read ports: later write ports overwrite earlier matches, so the highest index forwards.
    always_comb begin
        rdata = '0;
        rrdy  = '1;
        for (int unsigned i = 0; i < NRD; i++) begin
            fwd_hit[i]  = 1'b0;
            fwd_data[i] = '0;
            for (int unsigned k = 0; k < NWR; k++) begin
                if (wen[k] && (waddr[k*AW +: AW] == raddr[i*AW +: AW])) begin
                    fwd_hit[i]  = 1'b1;
                    fwd_data[i] = wdata[k*XLEN +: XLEN];
                end
            end
            if (ren[i] && (raddr[i*AW +: AW] != '0)) begin
                if (fwd_hit[i]) begin
                    rdata[i*XLEN +: XLEN] = fwd_data[i];
                end else begin
                    rdata[i*XLEN +: XLEN] = rf_q[raddr[i*AW +: AW]];
                    rrdy[i]               = ~busy_q[raddr[i*AW +: AW]];
                end
            end
        end
    end

    // A same-cycle write-back to the destination frees it for the new producer.
    always_comb begin
        iss_wb_hit = 1'b0;
        for (int unsigned k = 0; k < NWR; k++) begin
            if (wen[k] && (waddr[k*AW +: AW] == iss_rd)) begin
                iss_wb_hit = 1'b1;
            end
        end
        iss_ready = (iss_rd == '0) || !busy_q[iss_rd] || iss_wb_hit;
    end

    always_comb begin
        rf_d = rf_q;
        for (int unsigned k = 0; k < NWR; k++) begin
            if (wen[k] && (waddr[k*AW +: AW] != '0)) begin
                rf_d[waddr[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
            end
        end
    end

    // Priority, lowest to highest: write-back clear, issue set, flush.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned k = 0; k < NWR; k++) begin
            if (wen[k]) begin
                busy_d[waddr[k*AW +: AW]] = 1'b0;
            end
        end
        if (iss_valid && iss_ready && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            busy_cnt = busy_cnt + {{AW{1'b0}}, busy_q[r]};
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                rf_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                rf_q[r] <= rf_d[r];
            end
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_rf_sb.sv
// Table-driven directed bench for ysyx_25040111_rf_sb (2 read ports, 2 write ports, 16x32).
// Each vector drives inputs, checks the combinational outputs, then takes one clock edge.
module tb_ysyx_25040111_rf_sb;

    logic        clock;
    logic        resetn;
    logic [1:0]  ren;
    logic [7:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rrdy;
    logic [1:0]  wen;
    logic [7:0]  waddr;
    logic [63:0] wdata;
    logic        iss_valid;
    logic [3:0]  iss_rd;
    logic        iss_ready;
    logic        flush;
    logic [4:0]  busy_cnt;

    int total = 0;
    int bad   = 0;

    ysyx_25040111_rf_sb dut (
        .clock     (clock),
        .resetn    (resetn),
        .ren       (ren),
        .raddr     (raddr),
        .rdata     (rdata),
        .rrdy      (rrdy),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .flush     (flush),
        .busy_cnt  (busy_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst_n;
        logic        fl;
        logic [1:0]  re;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [1:0]  we;
        logic [3:0]  wa0;
        logic [31:0] wd0;
        logic [3:0]  wa1;
        logic [31:0] wd1;
        logic        iv;
        logic [3:0]  ird;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_rrdy;
        logic        e_rdy;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rst_n, logic fl, logic [1:0] re, logic [3:0] ra0,
                                logic [3:0] ra1, logic [1:0] we, logic [3:0] wa0,
                                logic [31:0] wd0, logic [3:0] wa1, logic [31:0] wd1,
                                logic iv, logic [3:0] ird, logic [31:0] e_rd0,
                                logic [31:0] e_rd1, logic [1:0] e_rrdy, logic e_rdy,
                                logic [4:0] e_cnt);
        vec_t v;
        v.rst_n = rst_n; v.fl = fl; v.re = re; v.ra0 = ra0; v.ra1 = ra1;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.iv = iv; v.ird = ird; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
        v.e_rrdy = e_rrdy; v.e_rdy = e_rdy; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        resetn    = v.rst_n;
        flush     = v.fl;
        ren       = v.re;
        raddr     = {v.ra1, v.ra0};
        wen       = v.we;
        waddr     = {v.wa1, v.wa0};
        wdata     = {v.wd1, v.wd0};
        iss_valid = v.iv;
        iss_rd    = v.ird;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        chk($sformatf("v%0d rdata0", idx), {32'h0, rdata[31:0]}, {32'h0, v.e_rd0});
        chk($sformatf("v%0d rdata1", idx), {32'h0, rdata[63:32]}, {32'h0, v.e_rd1});
        chk($sformatf("v%0d rrdy", idx), {62'h0, rrdy}, {62'h0, v.e_rrdy});
        chk($sformatf("v%0d iss_ready", idx), {63'h0, iss_ready}, {63'h0, v.e_rdy});
        chk($sformatf("v%0d busy_cnt", idx), {59'h0, busy_cnt}, {59'h0, v.e_cnt});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t z;
        z = mk(0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1, 0);
        drive(z);
        tick();
        tick();

        //        rst fl ren   ra0 ra1 wen    wa0 wd0           wa1 wd1       iv ird  rd0           rd1       rrdy  rdy cnt
        // Random writes and an issue, then reset for two cycles
        vq.push_back(mk(1, 0, 2'b11, 3,  8,  2'b11, 3,  32'hAAAA,     8,  32'hBBBB, 0, 0,  32'hAAAA,     32'hBBBB, 2'b11, 1, 0));
        vq.push_back(mk(1, 0, 2'b11, 3,  8,  2'b00, 0,  0,            0,  0,        1, 10, 32'hAAAA,     32'hBBBB, 2'b11, 1, 0));
        vq.push_back(mk(0, 0, 2'b11, 3,  10, 2'b01, 5,  32'h77,       0,  0,        0, 10, 32'hAAAA,     0,        2'b01, 0, 1));
        vq.push_back(mk(0, 0, 2'b11, 3,  8,  2'b00, 0,  0,            0,  0,        0, 10, 0,            0,        2'b11, 1, 0));
        vq.push_back(mk(1, 0, 2'b11, 5,  10, 2'b00, 0,  0,            0,  0,        0, 10, 0,            0,        2'b11, 1, 0));
        // Write r5, write to r0 discarded, read-enable gating
        vq.push_back(mk(1, 0, 2'b00, 0,  0,  2'b01, 5,  32'hDEADBEEF, 0,  0,        0, 0,  0,            0,        2'b11, 1, 0));
        vq.push_back(mk(1, 0, 2'b11, 5,  0,  2'b01, 0,  32'h1234,     0,  0,        0, 0,  32'hDEADBEEF, 0,        2'b11, 1, 0));
        vq.push_back(mk(1, 0, 2'b11, 0,  5,  2'b00, 0,  0,            0,  0,        0, 0,  0,            32'hDEADBEEF, 2'b11, 1, 0));
        vq.push_back(mk(1, 0, 2'b00, 5,  5,  2'b00, 0,  0,            0,  0,        0, 0,  0,            0,        2'b11, 1, 0));
        // Write collision: port 1 wins, both for forwarding and the stored value
        vq.push_back(mk(1, 0, 2'b01, 3,  3,  2'b11, 3,  32'h11,       3,  32'h22,   0, 0,  32'h22,       0,        2'b11, 1, 0));
        vq.push_back(mk(1, 0, 2'b11, 3,  3,  2'b00, 0,  0,            0,  0,        0, 0,  32'h22,       32'h22,   2'b11, 1, 0));
        // RAW stall on r7, released by a port-1 write-back
        vq.push_back(mk(1, 0, 2'b11, 7,  3,  2'b00, 0,  0,            0,  0,        1, 7,  0,            32'h22,   2'b11, 1, 0));
        vq.push_back(mk(1, 0, 2'b11, 7,  3,  2'b00, 0,  0,            0,  0,        0, 7,  0,            32'h22,   2'b10, 0, 1));
        vq.push_back(mk(1, 0, 2'b11, 7,  7,  2'b10, 0,  0,            7,  32'h55,   0, 7,  32'h55,       32'h55,   2'b11, 1, 1));
        vq.push_back(mk(1, 0, 2'b11, 7,  0,  2'b00, 0,  0,            0,  0,        0, 7,  32'h55,       0,        2'b11, 1, 0));
        // WAW: r9 busy stalls, same-cycle write-back accepts and set beats clear
        vq.push_back(mk(1, 0, 2'b00, 0,  0,  2'b00, 0,  0,            0,  0,        1, 9,  0,            0,        2'b11, 1, 0));
        vq.push_back(mk(1, 0, 2'b01, 9,  0,  2'b00, 0,  0,            0,  0,        1, 9,  0,            0,        2'b10, 0, 1));
        vq.push_back(mk(1, 0, 2'b01, 9,  0,  2'b01, 9,  32'h99,       0,  0,        1, 9,  32'h99,       0,        2'b11, 1, 1));
        vq.push_back(mk(1, 0, 2'b01, 9,  0,  2'b00, 0,  0,            0,  0,        0, 9,  32'h99,       0,        2'b10, 0, 1));
        vq.push_back(mk(1, 0, 2'b00, 0,  0,  2'b01, 9,  32'h99,       0,  0,        0, 9,  0,            0,        2'b11, 1, 1));
        // Flush beats a same-cycle issue; the rf write still lands
        vq.push_back(mk(1, 0, 2'b00, 0,  0,  2'b00, 0,  0,            0,  0,        1, 1,  0,            0,        2'b11, 1, 0));
        vq.push_back(mk(1, 0, 2'b00, 0,  0,  2'b00, 0,  0,            0,  0,        1, 2,  0,            0,        2'b11, 1, 1));
        vq.push_back(mk(1, 0, 2'b00, 0,  0,  2'b00, 0,  0,            0,  0,        1, 4,  0,            0,        2'b11, 1, 2));
        vq.push_back(mk(1, 0, 2'b00, 0,  0,  2'b00, 0,  0,            0,  0,        0, 4,  0,            0,        2'b11, 0, 3));
        vq.push_back(mk(1, 1, 2'b01, 1,  0,  2'b01, 12, 32'hCAFE,     0,  0,        1, 6,  0,            0,        2'b10, 1, 3));
        vq.push_back(mk(1, 0, 2'b11, 12, 6,  2'b00, 0,  0,            0,  0,        0, 6,  32'hCAFE,     0,        2'b11, 1, 0));
        // Same again with a mid-operation reset
        vq.push_back(mk(1, 0, 2'b00, 0,  0,  2'b00, 0,  0,            0,  0,        1, 1,  0,            0,        2'b11, 1, 0));
        vq.push_back(mk(1, 0, 2'b00, 0,  0,  2'b00, 0,  0,            0,  0,        1, 2,  0,            0,        2'b11, 1, 1));
        vq.push_back(mk(1, 0, 2'b00, 0,  0,  2'b00, 0,  0,            0,  0,        1, 4,  0,            0,        2'b11, 1, 2));
        vq.push_back(mk(1, 0, 2'b00, 0,  0,  2'b00, 0,  0,            0,  0,        0, 4,  0,            0,        2'b11, 0, 3));
        vq.push_back(mk(0, 0, 2'b11, 12, 4,  2'b00, 0,  0,            0,  0,        1, 6,  32'hCAFE,     0,        2'b01, 1, 3));
        vq.push_back(mk(1, 0, 2'b11, 12, 5,  2'b00, 0,  0,            0,  0,        0, 6,  0,            0,        2'b11, 1, 0));

        foreach (vq[i]) begin
            drive(vq[i]);
            #2;
            check_vec(i, vq[i]);
            tick();
        end

        // Issue to r0 never marks anything busy
        z = mk(1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b11, 1, 0);
        drive(z);
        #2;
        chk("iss_r0 ready", {63'h0, iss_ready}, 64'h1);
        tick();
        z.iv = 1'b0;
        drive(z);
        #2;
        chk("iss_r0 busy_cnt", {59'h0, busy_cnt}, 64'h0);

        // Port 1 targets r0 while port 0 writes r13: only port 0 may forward and store
        z = mk(1, 0, 2'b01, 13, 0, 2'b11, 13, 32'hAB, 0, 32'hCD, 0, 0, 0, 0, 2'b11, 1, 0);
        drive(z);
        #2;
        chk("r0_shadow fwd", {32'h0, rdata[31:0]}, 64'hAB);
        tick();
        z.we = 2'b00;
        z.re = 2'b11;
        z.ra1 = 4'd0;
        drive(z);
        #2;
        chk("r0_shadow r13", {32'h0, rdata[31:0]}, 64'hAB);
        chk("r0_shadow r0", {32'h0, rdata[63:32]}, 64'h0);

        // Two busy registers read side by side, then a double write-back clears both
        z = mk(1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 14, 0, 0, 2'b11, 1, 0);
        drive(z);
        tick();
        z.ird = 4'd15;
        drive(z);
        tick();
        z = mk(1, 0, 2'b11, 14, 15, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2);
        drive(z);
        #2;
        chk("dual_busy rrdy", {62'h0, rrdy}, 64'h0);
        chk("dual_busy cnt", {59'h0, busy_cnt}, 64'h2);
        z.we = 2'b11; z.wa0 = 4'd14; z.wd0 = 32'h1414; z.wa1 = 4'd15; z.wd1 = 32'h1515;
        drive(z);
        #2;
        chk("dual_wb rdata", rdata, 64'h0000_1515_0000_1414);
        tick();
        z.we = 2'b00;
        drive(z);
        #2;
        chk("dual_wb cnt", {59'h0, busy_cnt}, 64'h0);
        chk("dual_wb rrdy", {62'h0, rrdy}, 64'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
